// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the M-stage data-memory controller.
//   SIZE_*         funct3 encodings of load/store access sizes
//   dmem_state_t   controller FSM states
//   is_misaligned  true when an access of the given size is not naturally aligned
package rv32i_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_H, SIZE_HU: mis = addr_lo[0];
      SIZE_W:          mis = (addr_lo != 2'b00);
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv32i_dmem_ctrl_storealign.sv
// storealign: combinational store-lane alignment.
//   size_i     funct3 of the store
//   addr_lo_i  low two bits of the byte address
//   wd_i       store source register value
//   be_o       byte enables for the addressed lanes
//   wdata_o    store data replicated onto every lane
module storealign
  import rv32i_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = '1;
    wdata_o = wd_i;
    case (size_i)
      SIZE_B, SIZE_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wd_i[7:0]}};
      end
      SIZE_H, SIZE_HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wd_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_ctrl.sv
// rv32i_dmem_ctrl: M-stage data-memory access controller.
//   clk, rst                 pipeline clock, asynchronous active-low reset
//   MemReadM/MemWriteM       load/store in M stage (both set = store)
//   SizeM, ALUResultM        access size and byte address
//   WriteDataM               store source value
//   mem_req..mem_wdata       registered bus request, held until mem_ready
//   mem_ready, mem_rdata     completion pulse and read word
//   ReadDataMTick            raw read word captured on load completion
//   StallM                   freezes F/D/E/M while an access is outstanding
//   MisalignedM, BusErrM     misaligned-access and bus-timeout pulses
module rv32i_dmem_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        SizeM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ReadDataMTick,
  output logic              StallM,
  output logic              MisalignedM,
  output logic              BusErrM
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);

  dmem_state_t       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_req_q, mem_we_q, bus_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q, rdtick_q;

  logic        acc, mis, go;
  logic [3:0]  sa_be;
  logic [31:0] sa_wdata;

  storealign u_storealign (
    .size_i    (SizeM),
    .addr_lo_i (ALUResultM[1:0]),
    .wd_i      (WriteDataM),
    .be_o      (sa_be),
    .wdata_o   (sa_wdata)
  );

  assign acc = MemReadM | MemWriteM;
  assign mis = is_misaligned(SizeM, ALUResultM[1:0]);
  assign go  = acc & ~mis;

  // Gated with rst so reset clears these immediately even though the
  // reset state (IDLE) would otherwise decode the held M-stage inputs.
  assign StallM      = rst & (((state_q == IDLE) & go) | (state_q == REQ));
  assign MisalignedM = rst & (state_q == IDLE) & acc & mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdtick_q    <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            mem_addr_q  <= {ALUResultM[ADDR_W-1:2], 2'b00};
            mem_we_q    <= MemWriteM;
            mem_be_q    <= MemWriteM ? sa_be : '1;
            mem_wdata_q <= MemWriteM ? sa_wdata : '0;
            mem_req_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) rdtick_q <= mem_rdata;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            bus_err_q <= 1'b1;
            mem_req_q <= 1'b0;
            cnt_q     <= CNT_MAX;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign ReadDataMTick = rdtick_q;
  assign BusErrM       = bus_err_q;

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// tb_rv32i_dmem_ctrl: self-checking bench for rv32i_dmem_ctrl (MAX_WAIT=8).
// Expected bus transactions and load data are queued when an access is
// driven and popped when the DUT presents the request / completes the load.
module tb_rv32i_dmem_ctrl;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  SizeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataMTick;
  logic        StallM, MisalignedM, BusErrM;

  always #5 clk = ~clk;

  rv32i_dmem_ctrl #(.ADDR_W(32), .MAX_WAIT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .MemReadM      (MemReadM),
    .MemWriteM     (MemWriteM),
    .SizeM         (SizeM),
    .ALUResultM    (ALUResultM),
    .WriteDataM    (WriteDataM),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ReadDataMTick (ReadDataMTick),
    .StallM        (StallM),
    .MisalignedM   (MisalignedM),
    .BusErrM       (BusErrM)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_rdtick;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic txn_t model_txn(input logic wr, input logic [2:0] sz,
                                     input logic [31:0] addr, input logic [31:0] wd);
    txn_t t;
    t.we   = wr;
    t.addr = addr & 32'hFFFF_FFFC;
    if (!wr) begin
      t.be    = 4'hF;
      t.wdata = 32'h0;
    end else if (sz == SZ_B || sz == SZ_BU) begin
      t.be    = 4'b0001 << addr[1:0];
      t.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
    end else if (sz == SZ_H || sz == SZ_HU) begin
      t.be    = addr[1] ? 4'hC : 4'h3;
      t.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
    end else begin
      t.be    = 4'hF;
      t.wdata = wd;
    end
    return t;
  endfunction

  // One aligned access from IDLE through DONE; bus answers after 'waits' cycles.
  task automatic drive_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, input int waits,
                              input logic [31:0] rdata);
    txn_t got, exp;
    MemReadM = rd; MemWriteM = wr; SizeM = sz; ALUResultM = addr; WriteDataM = wd;
    exp_q.push_back(model_txn(wr, sz, addr, wd));
    if (rd && !wr) rd_q.push_back(rdata);
    exp = '0;
    @(negedge clk);
    n_checks++;
    if (StallM !== 1'b1 || mem_req !== 1'b0 || MisalignedM !== 1'b0 || ReadDataMTick !== exp_rdtick) begin
      n_fail++;
      $display("FAIL %s idle: StallM=%b mem_req=%b MisalignedM=%b rdtick=%h, want 1 0 0 %h",
               name, StallM, mem_req, MisalignedM, ReadDataMTick, exp_rdtick);
    end
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rdata : $urandom;
      @(negedge clk);
      if (i == 0) exp = exp_q.pop_front();
      got = {mem_we, mem_addr, mem_be, mem_wdata};
      n_checks++;
      if (mem_req !== 1'b1 || StallM !== 1'b1 || BusErrM !== 1'b0) begin
        n_fail++;
        $display("FAIL %s req cycle %0d: mem_req=%b StallM=%b BusErrM=%b, want 1 1 0",
                 name, i, mem_req, StallM, BusErrM);
      end
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s bus cycle %0d: we=%b addr=%h be=%b wdata=%h, want we=%b addr=%h be=%b wdata=%h",
                 name, i, got.we, got.addr, got.be, got.wdata, exp.we, exp.addr, exp.be, exp.wdata);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    mem_rdata = $urandom;
    @(negedge clk);
    if (rd && !wr) exp_rdtick = rd_q.pop_front();
    n_checks++;
    if (mem_req !== 1'b0 || StallM !== 1'b0 || BusErrM !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: mem_req=%b StallM=%b BusErrM=%b, want 0 0 0",
               name, mem_req, StallM, BusErrM);
    end
    n_checks++;
    if (ReadDataMTick !== exp_rdtick) begin
      n_fail++;
      $display("FAIL %s rdtick: got %h want %h", name, ReadDataMTick, exp_rdtick);
    end
    // stray completion in DONE must be ignored
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; SizeM = SZ_W;
    ALUResultM = '0; WriteDataM = '0; mem_ready = 1'b0; mem_rdata = '0;
    exp_rdtick = '0;
    #3;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadDataMTick, StallM, MisalignedM, BusErrM} !== '0) begin
      n_fail++;
      $display("FAIL reset: req=%b we=%b addr=%h be=%b wdata=%h rdtick=%h stall=%b mis=%b berr=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadDataMTick, StallM, MisalignedM, BusErrM);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b0 || StallM !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: mem_req=%b StallM=%b, want 0 0", mem_req, StallM);
    end
  endtask

  task automatic test_sb;
    drive_access("sb_1003", 1'b0, 1'b1, SZ_B, 32'h0000_1003, 32'h1234_56AB, 1, 32'h0);
  endtask

  task automatic test_lw_wait;
    drive_access("lw_2000", 1'b1, 1'b0, SZ_W, 32'h0000_2000, 32'h0, 4, 32'hDEAD_BEEF);
  endtask

  task automatic test_misaligned;
    MemReadM = 1'b1; MemWriteM = 1'b0; SizeM = SZ_H; ALUResultM = 32'h0000_0005;
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (MisalignedM !== 1'b1 || StallM !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned %0d: MisalignedM=%b StallM=%b mem_req=%b, want 1 0 0",
                 k, MisalignedM, StallM, mem_req);
      end
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b1; SizeM = SZ_W; ALUResultM = 32'h0000_0006;
      WriteDataM = 32'hFFFF_FFFF;
    end
    MemWriteM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (MisalignedM !== 1'b0 || mem_req !== 1'b0 || ReadDataMTick !== exp_rdtick) begin
      n_fail++;
      $display("FAIL misaligned_after: MisalignedM=%b mem_req=%b rdtick=%h, want 0 0 %h",
               MisalignedM, mem_req, ReadDataMTick, exp_rdtick);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    drive_access("sh_3002", 1'b0, 1'b1, SZ_H, 32'h0000_3002, 32'hCAFE_BEEF, 0, 32'h0);
    drive_access("lbu_3001", 1'b1, 1'b0, SZ_BU, 32'h0000_3001, 32'h0, 0, 32'h0000_00A5);
    drive_access("rw_both", 1'b1, 1'b1, SZ_W, 32'h0000_7000, 32'h1122_3344, 0, 32'h0);
    drive_access("lhu_7002", 1'b1, 1'b0, SZ_HU, 32'h0000_7002, 32'h0, 2, 32'h8765_4321);
  endtask

  task automatic test_store_random;
    logic [31:0] a;
    logic [2:0]  sz;
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      case (k % 3)
        0:       sz = SZ_B;
        1:       begin sz = SZ_H; a[0] = 1'b0; end
        default: begin sz = SZ_W; a[1:0] = 2'b00; end
      endcase
      drive_access("st_rand", 1'b0, 1'b1, sz, a, $urandom, int'($urandom_range(3, 0)), 32'h0);
    end
  endtask

  task automatic test_timeout;
    MemReadM = 1'b1; MemWriteM = 1'b0; SizeM = SZ_W; ALUResultM = 32'h0000_4000;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || StallM !== 1'b1 || BusErrM !== 1'b0 || mem_addr !== 32'h0000_4000) begin
        n_fail++;
        $display("FAIL timeout req %0d: mem_req=%b StallM=%b BusErrM=%b addr=%h, want 1 1 0 00004000",
                 i, mem_req, StallM, BusErrM, mem_addr);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || StallM !== 1'b0 || BusErrM !== 1'b1 || ReadDataMTick !== exp_rdtick) begin
      n_fail++;
      $display("FAIL timeout done: mem_req=%b StallM=%b BusErrM=%b rdtick=%h, want 0 0 1 %h",
               mem_req, StallM, BusErrM, ReadDataMTick, exp_rdtick);
    end
    @(posedge clk); #1;
    MemReadM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || StallM !== 1'b0 || BusErrM !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout idle: mem_req=%b StallM=%b BusErrM=%b, want 0 0 0",
               mem_req, StallM, BusErrM);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    MemReadM = 1'b1; MemWriteM = 1'b0; SizeM = SZ_W; ALUResultM = 32'h0000_5000;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid pre: mem_req=%b, want 1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    exp_rdtick = '0;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadDataMTick, StallM, MisalignedM, BusErrM} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: req=%b we=%b addr=%h be=%b wdata=%h rdtick=%h stall=%b mis=%b berr=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadDataMTick, StallM, MisalignedM, BusErrM);
    end
    MemReadM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    drive_access("lw_after_rst", 1'b1, 1'b0, SZ_W, 32'h0000_6000, 32'h0, 0, 32'h1357_9BDF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sb();
    test_lw_wait();
    test_misaligned();
    test_back_to_back();
    test_store_random();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d txn and %0d loads left, want 0 0", exp_q.size(), rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
